// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, FIFO default depth and system clock rate.
package uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam int unsigned CLK_FREQ        = 50000000;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_byte_ram.sv
// Byte register array: one synchronous write port, one combinational read port.
module uart_byte_ram
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = UART_FIFO_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  byte_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output byte_t             rdata
);

  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO between the RX deserializer and the TX-side consumer.
// First-word-fall-through read, sticky overflow on dropped RX bytes.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = UART_FIFO_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_next;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign pop_c  = out_valid && out_ready;
  assign push_c = in_valid && (!full || pop_c);
  assign drop_c = in_valid && full && !pop_c;

  always_comb begin
    count_next = count;
    if (push_c && !pop_c)      count_next = count + CNT_W'(1);
    else if (pop_c && !push_c) count_next = count - CNT_W'(1);
  end

  // out_valid and full are kept as flops tracking the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count     <= count_next;
      out_valid <= (count_next != '0);
      full      <= (count_next == CNT_W'(DEPTH));
      overflow  <= drop_c || (overflow && !overflow_clr);
    end
  end

  uart_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_c && !rst),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       overflow_clr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  logic       ovf;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(ovf));
    if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // One clock: compare state, drive inputs, advance the model by the FIFO rules.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
    bit pop, drop;
    check_state();
    in_valid = iv; in_data = d; out_ready = rdy; overflow_clr = clr;
    pop  = (q.size() != 0) && rdy;
    drop = iv && (q.size() == DEPTH) && !pop;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (iv && !drop) q.push_back(d);
    if (drop) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
    #1;
    in_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
  endtask

  task automatic do_reset(input logic iv);
    check_state();
    rst = 1'b1; in_valid = iv; in_data = 8'($urandom); out_ready = 1'b1;
    @(posedge clk);
    q.delete(); ovf = 1'b0;
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sent[$];
    logic [7:0] got[$];
    logic [7:0] exp3[$];
    int pushed;
    int guard;
    logic iv, rdy, clr;
    logic [7:0] d;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; overflow_clr = 1'b0;
    ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_count", 32'(count), 0);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_full", 32'(full), 0);
    check("reset_ovf", 32'(overflow), 0);

    // Three pushes held, then drained with out_ready high.
    cycle(1, 8'h11, 0, 0);
    check("t1_valid_after_first", 32'(out_valid), 1);
    check("t1_head_after_first", 32'(out_data), 32'h11);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    check("t1_count3", 32'(count), 3);
    check("t1_head", 32'(out_data), 32'h11);
    cycle(0, 0, 0, 0);
    check("t1_head_stable", 32'(out_data), 32'h11);
    check("t1_pop1", 32'(out_data), 32'h11); cycle(0, 0, 1, 0);
    check("t1_pop2", 32'(out_data), 32'h22); cycle(0, 0, 1, 0);
    check("t1_pop3", 32'(out_data), 32'h33); cycle(0, 0, 1, 0);
    check("t1_empty", 32'(out_valid), 0);

    // Fill, drop one byte, drain without it.
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
    check("t2_full", 32'(full), 1);
    check("t2_count16", 32'(count), 16);
    cycle(1, 8'hAA, 0, 0);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_count_after_drop", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", 32'(out_data), 32'(i));
      cycle(0, 0, 1, 0);
    end
    check("t2_drained", 32'(out_valid), 0);

    // Push and pop together while full.
    do_reset(0);
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'h55, 1, 0);
    check("t3_count16", 32'(count), 16);
    check("t3_no_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) exp3.push_back(8'(i));
    exp3.push_back(8'h55);
    foreach (exp3[i]) begin
      check("t3_drain", 32'(out_data), 32'(exp3[i]));
      cycle(0, 0, 1, 0);
    end
    check("t3_drained", 32'(out_valid), 0);

    // Push into empty with out_ready already high.
    cycle(1, 8'h7E, 1, 0);
    check("t4_count1", 32'(count), 1);
    check("t4_data", 32'(out_data), 32'h7E);
    cycle(0, 0, 1, 0);
    check("t4_count0", 32'(count), 0);

    // Random traffic kept below full; pointers wrap at least twice.
    pushed = 0; guard = 0;
    while ((pushed < 40 || q.size() != 0) && guard < 1000) begin
      iv  = (pushed < 40) && (q.size() < DEPTH - 1) && ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      d   = 8'($urandom);
      if (iv) begin sent.push_back(d); pushed++; end
      if (out_valid && rdy) got.push_back(out_data);
      cycle(iv, d, rdy, 0);
      guard++;
    end
    check("rand_finished", 32'(guard < 1000), 1);
    check("rand_len", 32'(got.size()), 32'(sent.size()));
    foreach (sent[i]) if (i < got.size()) check("rand_order", 32'(got[i]), 32'(sent[i]));

    // Random stress with overflow pressure, clears and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1'($urandom));
      else cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0));
    end

    // Overflow set/clear priority, then reset with data buffered.
    do_reset(0);
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h80 + i), 0, 0);
    cycle(1, 8'hC3, 0, 0);
    check("t6_ovf_set", 32'(overflow), 1);
    cycle(1, 8'hC4, 0, 1);
    check("t6_set_wins", 32'(overflow), 1);
    cycle(0, 0, 0, 1);
    check("t6_cleared", 32'(overflow), 0);
    do_reset(0);
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    check("t6_count5", 32'(count), 5);
    do_reset(1);
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_valid", 32'(out_valid), 0);
    cycle(0, 0, 1, 0);
    check_state();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
